// File: rtl/pc_redirect_unit.sv
// IF-stage fetch PC with ID-stage branch/jump redirect and stall-deferred apply.
// Optional BRANCH_PERF_EN adds branch and redirect event counters.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        id_valid_i,
    input  logic        id_is_branch_i,
    input  logic        id_is_jal_i,
    input  logic        id_is_jalr_i,
    input  logic        id_taken_i,
    input  logic [31:0] id_pc_i,
    input  logic [31:0] id_imm_i,
    input  logic [31:0] id_rs1_i,
`ifdef BRANCH_PERF_EN
    output logic [31:0] perf_br_o,
    output logic [31:0] perf_redir_o,
`endif
    output logic [31:0] pc_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic        misalign_o,
    output logic        busy_o
);

    typedef enum logic {RUN, PEND} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_tgt;
    logic [31:0] w_tgt_nxt;
    logic        w_cf;
    logic        w_req;
    logic [31:0] w_base;
    logic [31:0] w_sum;
    logic [31:0] w_tgt;

    assign w_cf   = id_is_branch_i | id_is_jal_i | id_is_jalr_i;
    assign w_req  = id_valid_i
                  & ((id_is_branch_i & id_taken_i)
                  | id_is_jal_i | id_is_jalr_i);
    assign w_base = id_is_jalr_i ? id_rs1_i : id_pc_i;
    assign w_sum  = w_base + id_imm_i;
    assign w_tgt  = id_is_jalr_i ? (w_sum & ~32'h1) : w_sum;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_tgt_nxt   = r_tgt;
        flush_o     = 1'b0;
        redirect_o  = 1'b0;
        misalign_o  = 1'b0;
        busy_o      = 1'b0;
        unique case (r_state)
            RUN: begin
                if (w_req) begin
                    flush_o    = 1'b1;
                    redirect_o = 1'b1;
                    misalign_o = w_tgt[1];
                    if (stall_i) begin
                        w_tgt_nxt   = w_tgt;
                        w_state_nxt = PEND;
                    end else begin
                        w_pc_nxt = w_tgt;
                    end
                end else if (!stall_i) begin
                    w_pc_nxt = r_pc + PC_STEP;
                end
            end
            PEND: begin
                // Younger fetches stay squashed until the target lands.
                flush_o = 1'b1;
                busy_o  = 1'b1;
                if (!stall_i) begin
                    w_pc_nxt    = r_tgt;
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_tgt   <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_tgt   <= w_tgt_nxt;
        end
    end

    assign pc_o = r_pc;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && r_state == PEND && w_req)
            $error("pc_redirect_unit: redirect request while pending");
    end
`endif

`ifdef BRANCH_PERF_EN
    logic [31:0] r_perf_br;
    logic [31:0] r_perf_redir;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_br    <= 32'h0;
            r_perf_redir <= 32'h0;
        end else if (r_state == RUN) begin
            if (id_valid_i && w_cf)
                r_perf_br <= r_perf_br + 32'd1;
            if (w_req)
                r_perf_redir <= r_perf_redir + 32'd1;
        end
    end

    assign perf_br_o    = r_perf_br;
    assign perf_redir_o = r_perf_redir;
`else
    logic w_unused;
    assign w_unused = w_cf;
`endif

endmodule
